// File: rtl/game_pkg.sv
// Shared types and constants for the game controller: FSM state encoding,
// key codes and the lives counter width.
package game_pkg;

  localparam int         LIVES_W    = 2;
  localparam logic [7:0] KEY_START  = 8'h28;
  localparam logic [7:0] KEY_ATTACK = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_HIT     = 3'd2,
    S_RESPAWN = 3'd3,
    S_WIN     = 3'd4,
    S_OVER    = 3'd5
  } state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and its environment; the
// controller side is the slave, the stimulus/host side is the master.
interface game_ctrl_if #(
  parameter int NUM_ENEMIES = 3
);
  logic [7:0]             keycode;
  logic [NUM_ENEMIES-1:0] enemy_touch;
  logic [NUM_ENEMIES-1:0] sword_hit;
  logic                   dead;
  logic [NUM_ENEMIES-1:0] enemy_dead_flag;
  logic [1:0]             lives;
  logic [2:0]             game_state;
  logic                   invuln;
  logic [7:0]             score;

  modport master (
    output keycode, enemy_touch, sword_hit,
    input  dead, enemy_dead_flag, lives, game_state, invuln, score
  );

  modport slave (
    input  keycode, enemy_touch, sword_hit,
    output dead, enemy_dead_flag, lives, game_state, invuln, score
  );
endinterface

// File: rtl/game_ctrl_frame_timer.sv
// Frame down-counter: load strobe with load value, decrement enable,
// done flags a count of zero. Used for the respawn and invulnerability timers.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: start/play/hit/respawn/win/over FSM with lives and
// sticky enemy kill flags. Define GAME_CTRL_SCORE_EN to enable the kill score.
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_ENEMIES    = 3,
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 30,
  parameter int INVULN_FRAMES  = 60
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [7:0]             keycode,
  input  logic [NUM_ENEMIES-1:0] enemy_touch,
  input  logic [NUM_ENEMIES-1:0] sword_hit,
  output logic                   dead,
  output logic [NUM_ENEMIES-1:0] enemy_dead_flag,
  output logic [LIVES_W-1:0]     lives,
  output logic [2:0]             game_state,
  output logic                   invuln,
  output logic [7:0]             score
);

  localparam int RT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam int IV_W = $clog2(INVULN_FRAMES + 1);

  state_e                 state_q, state_d;
  logic [NUM_ENEMIES-1:0] flags_q, flags_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic                   dead_q, dead_d;
  logic [7:0]             prev_key_q;

  logic                   start, damage;
  logic [NUM_ENEMIES-1:0] kill_v;
  logic                   rt_load, rt_dec, rt_done;
  logic                   iv_load, iv_dec, iv_done;
  logic [IV_W-1:0]        iv_val;

  // Edge-detect the start key so holding it down does not retrigger.
  assign start  = (keycode == KEY_START) && (prev_key_q != KEY_START);
  assign kill_v = (keycode == KEY_ATTACK) ? (sword_hit & ~flags_q) : '0;
  assign damage = (|(enemy_touch & ~flags_q & ~kill_v)) && iv_done;

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    lives_d = lives_q;
    rt_load = 1'b0;
    rt_dec  = 1'b0;
    iv_load = 1'b0;
    iv_val  = '0;
    iv_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          lives_d = LIVES_W'(LIVES_INIT);
          flags_d = '0;
          iv_load = 1'b1;
        end
      end
      S_PLAY: begin
        flags_d = flags_q | kill_v;
        iv_dec  = 1'b1;
        if (damage) begin
          state_d = S_HIT;
          lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
          rt_load = 1'b1;
        end else if (&flags_q) begin
          state_d = S_WIN;
        end
      end
      S_HIT: begin
        if (lives_q == '0)  state_d = S_OVER;
        else if (rt_done)   state_d = S_RESPAWN;
        else                rt_dec  = 1'b1;
      end
      S_RESPAWN: begin
        state_d = S_PLAY;
        iv_load = 1'b1;
        iv_val  = IV_W'(INVULN_FRAMES);
      end
      S_WIN, S_OVER: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    dead_d = (state_d == S_HIT) || (state_d == S_RESPAWN);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      flags_q    <= '0;
      lives_q    <= '0;
      dead_q     <= 1'b0;
      prev_key_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      lives_q    <= lives_d;
      dead_q     <= dead_d;
      prev_key_q <= keycode;
    end
  end

  frame_timer #(.W(RT_W)) u_respawn_timer (
    .clk   (frame_clk),
    .rst_n (Reset_n),
    .load  (rt_load),
    .value (RT_W'(RESPAWN_FRAMES - 1)),
    .dec   (rt_dec),
    .done  (rt_done)
  );

  frame_timer #(.W(IV_W)) u_invuln_timer (
    .clk   (frame_clk),
    .rst_n (Reset_n),
    .load  (iv_load),
    .value (iv_val),
    .dec   (iv_dec),
    .done  (iv_done)
  );

`ifdef GAME_CTRL_SCORE_EN
  logic [7:0] score_q;
  logic [7:0] kill_cnt;
  logic [8:0] score_sum;

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) kill_cnt = kill_cnt + 8'(kill_v[i]);
    score_sum = {1'b0, score_q} + {1'b0, kill_cnt};
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= 8'h00;
    end else if ((state_q == S_IDLE) && start) begin
      score_q <= 8'h00;
    end else if (state_q == S_PLAY) begin
      score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end

  assign score = score_q;
`else
  assign score = 8'h00;
`endif

  assign dead            = dead_q;
  assign enemy_dead_flag = flags_q;
  assign lives           = lives_q;
  assign game_state      = state_q;
  assign invuln          = ~iv_done;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start edge, hit/respawn/invuln timing,
// kills and win, game over and asynchronous reset mid-sequence.
module tb_game_ctrl;

  localparam int N = 3;

`ifdef GAME_CTRL_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   cnt;

  game_ctrl_if #(.NUM_ENEMIES(N)) gif ();

  game_ctrl #(.NUM_ENEMIES(N)) dut (
    .frame_clk       (frame_clk),
    .Reset_n         (Reset_n),
    .keycode         (gif.keycode),
    .enemy_touch     (gif.enemy_touch),
    .sword_hit       (gif.sword_hit),
    .dead            (gif.dead),
    .enemy_dead_flag (gif.enemy_dead_flag),
    .lives           (gif.lives),
    .game_state      (gif.game_state),
    .invuln          (gif.invuln),
    .score           (gif.score)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  // Run out any hit/respawn/invulnerability window and come back to vulnerable play.
  task automatic wait_play_clear();
    int guard = 0;
    while (!(gif.game_state == 3'd1 && gif.invuln == 1'b0) && guard < 300) begin
      tick();
      guard++;
    end
    check("wait_play_clear", {31'd0, (gif.game_state == 3'd1 && !gif.invuln)}, 32'd1);
  endtask

  initial begin
    gif.keycode     = 8'h00;
    gif.enemy_touch = '0;
    gif.sword_hit   = '0;
    #2;
    check("rst_state", gif.game_state, 3'd0);
    check("rst_dead",  gif.dead, 1'b0);
    check("rst_lives", gif.lives, 2'd0);
    check("rst_flags", gif.enemy_dead_flag, 3'b000);
    check("rst_inv",   gif.invuln, 1'b0);
    check("rst_score", gif.score, 8'h00);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();

    // Start edge, then holding the key must not change anything.
    gif.keycode = 8'h28; tick();
    check("start_state", gif.game_state, 3'd1);
    check("start_lives", gif.lives, 2'd3);
    check("start_flags", gif.enemy_dead_flag, 3'b000);
    tick(10);
    check("hold_state", gif.game_state, 3'd1);
    check("hold_lives", gif.lives, 2'd3);

    // Damage, 30 hit frames, 1 respawn frame, 60 invulnerable frames.
    gif.keycode = 8'h00; gif.enemy_touch = 3'b001; tick();
    gif.enemy_touch = 3'b000;
    check("hit_state", gif.game_state, 3'd2);
    check("hit_lives", gif.lives, 2'd2);
    check("hit_dead",  gif.dead, 1'b1);
    cnt = 0;
    while (gif.game_state == 3'd2 && gif.dead && cnt < 100) begin cnt++; tick(); end
    check("hit_frames", cnt, 30);
    check("respawn_state", gif.game_state, 3'd3);
    check("respawn_dead",  gif.dead, 1'b1);
    tick();
    check("post_respawn_state", gif.game_state, 3'd1);
    check("post_respawn_dead",  gif.dead, 1'b0);
    cnt = 0;
    gif.enemy_touch = 3'b111;
    while (gif.invuln && cnt < 5) begin cnt++; tick(); end
    check("inv_touch_state", gif.game_state, 3'd1);
    check("inv_touch_lives", gif.lives, 2'd2);
    gif.enemy_touch = 3'b000;
    while (gif.invuln && cnt < 200) begin cnt++; tick(); end
    check("inv_frames", cnt, 60);

    // Kill wins over touch by the same enemy.
    gif.keycode = 8'h2C; gif.sword_hit = 3'b010; gif.enemy_touch = 3'b010; tick();
    gif.enemy_touch = 3'b000;
    check("kill_flag",  gif.enemy_dead_flag, 3'b010);
    check("kill_state", gif.game_state, 3'd1);
    check("kill_score", gif.score, SCORE_ON ? 32'd1 : 32'd0);
    gif.sword_hit = 3'b011; tick();
    check("kill2_flag",  gif.enemy_dead_flag, 3'b011);
    check("kill2_score", gif.score, SCORE_ON ? 32'd2 : 32'd0);
    gif.sword_hit = 3'b100; tick();
    check("kill3_flag",  gif.enemy_dead_flag, 3'b111);
    check("kill3_state", gif.game_state, 3'd1);
    gif.keycode = 8'h00; gif.sword_hit = 3'b000; tick();
    check("win_state", gif.game_state, 3'd4);
    check("win_score", gif.score, SCORE_ON ? 32'd3 : 32'd0);
    tick(2);
    check("win_hold",  gif.game_state, 3'd4);
    check("win_lives", gif.lives, 2'd2);
    gif.keycode = 8'h28; tick();
    check("win_to_idle", gif.game_state, 3'd0);
    tick(3);
    check("idle_no_retrigger", gif.game_state, 3'd0);
    check("idle_flags_kept",   gif.enemy_dead_flag, 3'b111);
    gif.keycode = 8'h2C; gif.sword_hit = 3'b111; gif.enemy_touch = 3'b111; tick();
    check("idle_ignore", gif.game_state, 3'd0);
    gif.sword_hit = 3'b000; gif.enemy_touch = 3'b000;
    gif.keycode = 8'h00; tick();
    gif.keycode = 8'h28; tick();
    check("restart_state", gif.game_state, 3'd1);
    check("restart_flags", gif.enemy_dead_flag, 3'b000);
    check("restart_lives", gif.lives, 2'd3);
    check("restart_score", gif.score, 8'h00);

    // Kill 001 while live enemy 010 touches: damage still taken.
    gif.keycode = 8'h2C; gif.sword_hit = 3'b001; gif.enemy_touch = 3'b011; tick();
    gif.keycode = 8'h00; gif.sword_hit = 3'b000; gif.enemy_touch = 3'b000;
    check("mixed_state", gif.game_state, 3'd2);
    check("mixed_flags", gif.enemy_dead_flag, 3'b001);
    check("mixed_lives", gif.lives, 2'd2);
    wait_play_clear();
    gif.enemy_touch = 3'b010; tick();
    gif.enemy_touch = 3'b000;
    check("dmg2_lives", gif.lives, 2'd1);
    wait_play_clear();
    gif.enemy_touch = 3'b100; tick();
    gif.enemy_touch = 3'b000;
    check("dmg3_state", gif.game_state, 3'd2);
    check("dmg3_lives", gif.lives, 2'd0);
    tick();
    check("over_state", gif.game_state, 3'd5);
    check("over_dead",  gif.dead, 1'b0);

    // Restart and reset in the middle of a hit.
    gif.keycode = 8'h28; tick();
    check("over_to_idle", gif.game_state, 3'd0);
    gif.keycode = 8'h00; tick();
    gif.keycode = 8'h28; tick();
    gif.keycode = 8'h00; gif.enemy_touch = 3'b001; tick();
    gif.enemy_touch = 3'b000;
    tick(3);
    check("pre_rst_state", gif.game_state, 3'd2);
    Reset_n = 1'b0; #1;
    check("async_rst_state", gif.game_state, 3'd0);
    check("async_rst_dead",  gif.dead, 1'b0);
    check("async_rst_lives", gif.lives, 2'd0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick(40);
    check("post_rst_state", gif.game_state, 3'd0);
    check("post_rst_dead",  gif.dead, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
